// File: rtl/dp_ctrl_pkg.sv
// Shared types and sizing helpers for the datapath-group reset/debug controller.
package dp_ctrl_pkg;

    // Reset sequencer states.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } dp_state_e;

    // Default geometry of the group.
    localparam int unsigned DW_DEF     = 32;
    localparam int unsigned NCORES_DEF = 4;

    // One core's debug word at the default width.
    typedef logic [DW_DEF-1:0] dbg_word_t;

    // Select width for n channels, never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold the value n, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    // Readout select width for the default group size.
    localparam int unsigned SELW = sel_w(NCORES_DEF);

endpackage

// File: rtl/dp_wdt_chan.sv
// Single debug channel: per-core reset flop, stall watchdog and sticky STALL flag.
// With DP_WDT_AUTORST_EN defined, a new stall pulses the core's reset for
// ARST_CYCLES cycles; otherwise the stall flag is report-only.
module dp_wdt_chan #(
    parameter int unsigned DW          = 32,
    parameter int unsigned WDT_CYCLES  = 1024
`ifdef DP_WDT_AUTORST_EN
    ,
    parameter int unsigned ARST_CYCLES = 2
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          release_nxt,
    input  logic [DW-1:0] debug,
    output logic          core_res,
    output logic          stall
);

    localparam int unsigned CNT_W = $clog2(WDT_CYCLES + 1);

    logic [DW-1:0]    prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stall_q;
    logic             stall_set_c;
    logic             res_q;
    logic             res_d;

`ifdef DP_WDT_AUTORST_EN
    localparam int unsigned ARST_W = (ARST_CYCLES > 0) ? $clog2(ARST_CYCLES + 1) : 1;

    logic [ARST_W-1:0] arst_q;
    logic [ARST_W-1:0] arst_d;
`endif

    // Unchanged-word counter; frozen at zero while the core is held in reset.
    always_comb begin
        cnt_d = cnt_q;
        if (res_q) begin
            cnt_d = '0;
        end else if (debug != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(WDT_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
        stall_set_c = !stall_q && (cnt_d == CNT_W'(WDT_CYCLES));
    end

`ifdef DP_WDT_AUTORST_EN
    // Reset request: sequencer hold, or a countdown armed by the stall's rising edge.
    always_comb begin
        arst_d = arst_q;
        if (stall_set_c) begin
            arst_d = ARST_W'(ARST_CYCLES);
        end else if (arst_q != '0) begin
            arst_d = arst_q - 1'b1;
        end
        res_d = !release_nxt || (arst_d != '0);
    end

    // Auto-reset countdown register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arst_q <= '0;
        end else begin
            arst_q <= arst_d;
        end
    end
`else
    // Reset request comes from the sequencer alone.
    always_comb begin
        res_d = !release_nxt;
    end
`endif

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            res_q   <= 1'b1;
        end else begin
            prev_q  <= debug;
            cnt_q   <= cnt_d;
            stall_q <= stall_q || stall_set_c;
            res_q   <= res_d;
        end
    end

    assign core_res = res_q;
    assign stall    = stall_q;

endmodule

// File: rtl/dp_reset_debug_ctrl.sv
// Reset sequencer and debug monitor for a multi-core datapath group.
// Holds all cores in reset, releases them in staggered order, then watches
// each core's DEBUG word for stalls and offers an atomic snapshot readout.
// Optional feature macro: DP_WDT_AUTORST_EN (stall re-asserts that core's reset).
module dp_reset_debug_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned NCORES      = 4,
    parameter int unsigned DW          = 32,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned STAGGER     = 0,
    parameter int unsigned WDT_CYCLES  = 1024
) (
    input  logic                           XCLK,
    input  logic                           XRES,
    input  logic [NCORES-1:0][DW-1:0]      DEBUG,
    output logic [NCORES-1:0]              CORE_RES,
    output logic                           READY,
    output logic [NCORES-1:0]              STALL,
    input  logic                           SNAP_REQ,
    output logic                           SNAP_ACK,
    input  logic [sel_w(NCORES)-1:0]       SNAP_SEL,
    output logic [DW-1:0]                  SNAP_DATA
);

    localparam int unsigned SEL_W      = sel_w(NCORES);
    localparam int unsigned HOLD_W     = cnt_w(HOLD_CYCLES);
    localparam int unsigned STG_W      = cnt_w(STAGGER);
    localparam int unsigned STG_RELOAD = (STAGGER > 0) ? STAGGER - 1 : 0;

    dp_state_e          state_q;
    dp_state_e          state_d;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_d;
    logic [STG_W-1:0]   wait_q;
    logic [STG_W-1:0]   wait_d;
    logic [SEL_W-1:0]   idx_q;
    logic [SEL_W-1:0]   idx_d;
    logic [NCORES-1:0]  rel_q;
    logic [NCORES-1:0]  rel_d;
    logic               ready_q;
    logic               ready_d;

    logic [NCORES-1:0][DW-1:0] shadow_q;
    logic                      ack_q;
    logic [DW-1:0]             data_q;
    logic [DW-1:0]             data_d;

    // Sequencer next state: hold, then release cores one by one (or all at once).
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        ready_d = ready_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    hold_d  = '0;
                    state_d = ST_STAGGER;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_STAGGER: begin
                if (STAGGER == 0) begin
                    rel_d   = '1;
                    ready_d = 1'b1;
                    state_d = ST_RUN;
                end else if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    rel_d[idx_q] = 1'b1;
                    wait_d       = STG_W'(STG_RELOAD);
                    if (idx_q == SEL_W'(NCORES - 1)) begin
                        ready_d = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            wait_q  <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            ready_q <= ready_d;
        end
    end

    // One watchdog channel per core; each owns its CORE_RES and STALL bit.
    for (genvar k = 0; k < NCORES; k++) begin : g_chan
        dp_wdt_chan #(
            .DW          (DW),
            .WDT_CYCLES  (WDT_CYCLES)
`ifdef DP_WDT_AUTORST_EN
            ,
            .ARST_CYCLES (HOLD_CYCLES)
`endif
        ) u_chan (
            .clk         (XCLK),
            .rst_n       (XRES),
            .release_nxt (rel_d[k]),
            .debug       (DEBUG[k]),
            .core_res    (CORE_RES[k]),
            .stall       (STALL[k])
        );
    end

    // Readout mux; out-of-range selects read as zero.
    always_comb begin
        data_d = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (SNAP_SEL == SEL_W'(k)) begin
                data_d = shadow_q[k];
            end
        end
    end

    // Snapshot capture, acknowledge and registered readout.
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            shadow_q <= '0;
            ack_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            if (SNAP_REQ) begin
                shadow_q <= DEBUG;
            end
            ack_q  <= SNAP_REQ;
            data_q <= data_d;
        end
    end

    assign READY     = ready_q;
    assign SNAP_ACK  = ack_q;
    assign SNAP_DATA = data_q;

endmodule

// File: tb/tb_dp_reset_debug_ctrl.sv
// Directed bench: instance A (4 cores, no stagger) and instance B (5 cores,
// stagger 3) share clock, reset and snapshot request.
module tb_dp_reset_debug_ctrl;
    import dp_ctrl_pkg::*;

    localparam int unsigned NA = 4;
    localparam int unsigned NB = 5;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  xres;
    logic                  snap_req;
    logic [NA-1:0][DW-1:0] dbg_a;
    logic [NB-1:0][DW-1:0] dbg_b;
    logic [NA-1:0]         core_res_a;
    logic [NA-1:0]         stall_a;
    logic                  ready_a;
    logic                  ack_a;
    logic [1:0]            sel_a;
    logic [DW-1:0]         data_a;
    logic [NB-1:0]         core_res_b;
    logic [NB-1:0]         stall_b;
    logic                  ready_b;
    logic                  ack_b;
    logic [2:0]            sel_b;
    logic [DW-1:0]         data_b;

    logic                  tog_en;
    logic [NA-1:0]         tog_mask_a;
    logic [NB-1:0]         tog_mask_b;

    int checks = 0;
    int errors = 0;

    dp_reset_debug_ctrl #(
        .NCORES(NA), .DW(DW), .HOLD_CYCLES(2), .STAGGER(0), .WDT_CYCLES(8)
    ) u_dut_a (
        .XCLK(clk), .XRES(xres), .DEBUG(dbg_a), .CORE_RES(core_res_a),
        .READY(ready_a), .STALL(stall_a), .SNAP_REQ(snap_req),
        .SNAP_ACK(ack_a), .SNAP_SEL(sel_a), .SNAP_DATA(data_a)
    );

    dp_reset_debug_ctrl #(
        .NCORES(NB), .DW(DW), .HOLD_CYCLES(2), .STAGGER(3), .WDT_CYCLES(8)
    ) u_dut_b (
        .XCLK(clk), .XRES(xres), .DEBUG(dbg_b), .CORE_RES(core_res_b),
        .READY(ready_b), .STALL(stall_b), .SNAP_REQ(snap_req),
        .SNAP_ACK(ack_b), .SNAP_SEL(sel_b), .SNAP_DATA(data_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, settle, then toggle the non-frozen debug words.
    task automatic tick();
        @(posedge clk);
        #1;
        if (tog_en) begin
            for (int i = 0; i < int'(NA); i++) if (tog_mask_a[i]) dbg_a[i] = ~dbg_a[i];
            for (int i = 0; i < int'(NB); i++) if (tog_mask_b[i]) dbg_b[i] = ~dbg_b[i];
        end
    endtask

    // Hand-tabulated CORE_RES of instance B, e edges after XRES rises.
    function automatic logic [NB-1:0] exp_cr_b(input int e);
        if (e < 3)  return 5'h1F;
        if (e < 6)  return 5'h1E;
        if (e < 9)  return 5'h1C;
        if (e < 12) return 5'h18;
        if (e < 15) return 5'h10;
        return 5'h00;
    endfunction

    initial begin
        logic [NA-1:0] ecr_a;

        xres       = 1'b0;
        snap_req   = 1'b0;
        sel_a      = '0;
        sel_b      = '0;
        dbg_a      = '0;
        dbg_b      = '0;
        tog_en     = 1'b0;
        tog_mask_a = 4'b1011;
        tog_mask_b = 5'h1F;
        #2;
        tick();
        tick();

        check_eq("rst_core_res_a", 32'(core_res_a), 32'hF);
        check_eq("rst_ready_a",    32'(ready_a),    32'h0);
        check_eq("rst_stall_a",    32'(stall_a),    32'h0);
        check_eq("rst_ack_a",      32'(ack_a),      32'h0);
        check_eq("rst_data_a",     data_a,          32'h0);
        check_eq("rst_core_res_b", 32'(core_res_b), 32'h1F);

        // Release; core 2 of A frozen, everything else toggling.
        dbg_a[0] = 32'h1;
        dbg_a[1] = 32'h2;
        dbg_a[2] = 32'hDEAD_BEEF;
        dbg_a[3] = 32'h3;
        dbg_b    = {32'h50, 32'h40, 32'h30, 32'h20, 32'h10};
        tog_en   = 1'b1;
        xres     = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            ecr_a = (e < 3) ? 4'hF : 4'h0;
`ifdef DP_WDT_AUTORST_EN
            if (e == 11 || e == 12) ecr_a = 4'h4;
`endif
            check_eq($sformatf("seq_core_res_a@%0d", e), 32'(core_res_a), 32'(ecr_a));
            check_eq($sformatf("seq_ready_a@%0d", e),    32'(ready_a),    (e >= 3) ? 32'h1 : 32'h0);
            check_eq($sformatf("seq_stall_a@%0d", e),    32'(stall_a),    (e >= 11) ? 32'h4 : 32'h0);
            check_eq($sformatf("seq_core_res_b@%0d", e), 32'(core_res_b), 32'(exp_cr_b(e)));
            check_eq($sformatf("seq_ready_b@%0d", e),    32'(ready_b),    (e >= 15) ? 32'h1 : 32'h0);
            check_eq($sformatf("seq_stall_b@%0d", e),    32'(stall_b),    32'h0);
        end

        // Stall flag is sticky once the frozen word moves again.
        dbg_a[2] = 32'h1234_5678;
        tick();
        tick();
        check_eq("sticky_stall_a",    32'(stall_a),    32'h4);
        check_eq("sticky_core_res_a", 32'(core_res_a), 32'h0);
        check_eq("sticky_ready_a",    32'(ready_a),    32'h1);

        // Single snapshot pulse, then the words change.
        tog_en   = 1'b0;
        dbg_a    = {32'h3, 32'h2, 32'h1, 32'h0};
        dbg_b    = {32'h44, 32'h33, 32'h22, 32'h11, 32'h00};
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check_eq("snap_ack_a_hi", 32'(ack_a), 32'h1);
        check_eq("snap_ack_b_hi", 32'(ack_b), 32'h1);
        dbg_a = {32'h13, 32'h12, 32'h11, 32'h10};
        sel_a = 2'd2;
        sel_b = 3'd4;
        tick();
        check_eq("snap_ack_a_lo", 32'(ack_a), 32'h0);
        check_eq("snap_sel2_a",   data_a,     32'h2);
        check_eq("snap_sel4_b",   data_b,     32'h44);
        sel_a = 2'd3;
        sel_b = 3'd5;
        tick();
        check_eq("snap_sel3_a",   data_a,     32'h3);
        check_eq("snap_sel5_b",   data_b,     32'h0);
        sel_a = 2'd1;
        sel_b = 3'd7;
        tick();
        check_eq("snap_sel1_a",   data_a,     32'h1);
        check_eq("snap_sel7_b",   data_b,     32'h0);

        // Capture and select change on the same edge.
        dbg_a    = {32'h23, 32'h22, 32'h21, 32'h20};
        snap_req = 1'b1;
        sel_a    = 2'd3;
        tick();
        snap_req = 1'b0;
        check_eq("simul_old_a", data_a,      32'h3);
        check_eq("simul_ack_a", 32'(ack_a),  32'h1);
        tick();
        check_eq("simul_new_a", data_a,      32'h23);
        check_eq("simul_ack_lo", 32'(ack_a), 32'h0);

        // Request held high: recapture every edge, acknowledge stays high.
        sel_a    = 2'd0;
        snap_req = 1'b1;
        dbg_a[0] = 32'h30;
        tick();
        check_eq("held_ack_1", 32'(ack_a), 32'h1);
        dbg_a[0] = 32'h31;
        tick();
        check_eq("held_ack_2",  32'(ack_a), 32'h1);
        check_eq("held_data_2", data_a,     32'h30);
        dbg_a[0] = 32'h32;
        tick();
        check_eq("held_ack_3",  32'(ack_a), 32'h1);
        check_eq("held_data_3", data_a,     32'h31);
        snap_req = 1'b0;
        tick();
        check_eq("held_ack_end",  32'(ack_a), 32'h0);
        check_eq("held_data_end", data_a,     32'h32);

        // Reset in RUN, release, then reset again mid-stagger.
        tog_mask_a = 4'hF;
        tog_en     = 1'b1;
        xres       = 1'b0;
        #2;
        check_eq("arst_run_core_res_a", 32'(core_res_a), 32'hF);
        check_eq("arst_run_stall_a",    32'(stall_a),    32'h0);
        check_eq("arst_run_ready_a",    32'(ready_a),    32'h0);
        check_eq("arst_run_data_a",     data_a,          32'h0);
        check_eq("arst_run_core_res_b", 32'(core_res_b), 32'h1F);
        tick();
        xres = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        check_eq("mid_core_res_b", 32'(core_res_b), 32'h1E);
        xres = 1'b0;
        #2;
        check_eq("arst_stg_core_res_b", 32'(core_res_b), 32'h1F);
        check_eq("arst_stg_core_res_a", 32'(core_res_a), 32'hF);
        check_eq("arst_stg_ready_b",    32'(ready_b),    32'h0);
        check_eq("arst_stg_stall_b",    32'(stall_b),    32'h0);
        tick();
        xres = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            check_eq($sformatf("re_core_res_b@%0d", e), 32'(core_res_b), 32'(exp_cr_b(e)));
            check_eq($sformatf("re_core_res_a@%0d", e), 32'(core_res_a), (e < 3) ? 32'hF : 32'h0);
        end
        check_eq("re_ready_b", 32'(ready_b), 32'h1);
        check_eq("re_ready_a", 32'(ready_a), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_reset_debug_ctrl.md
Name: dp_reset_debug_ctrl

Overview:
Synthesisable reset sequencer and debug monitor for a darkdpgroup-style multi-core datapath group. It holds the cores in reset, then releases each core's reset in a staggered order. Once released, it watches every core's DEBUG word for stalls and provides an atomic snapshot/readout port for all channels. It replaces ad-hoc one-cycle reset generation with a parametrised, countable sequence.

Parameters:
NCORES, 4, number of cores/debug channels (1..16)
DW, 32, width of each DEBUG word
HOLD_CYCLES, 2, cycles all core resets stay asserted after XRES deassertion (>=1)
STAGGER, 0, cycles between successive per-core releases (0 = all released together)
WDT_CYCLES, 1024, number of unchanged-DEBUG cycles that flags a stall (>=2)

Ports:
XCLK  in  1  core clock
XRES  in  1  reset; asynchronous assert, active-low
DEBUG  in  [NCORES-1:0][DW-1:0]  per-core debug word
CORE_RES  out  NCORES  active-high reset to each core
READY  out  1  high once every core has been released
STALL  out  NCORES  sticky per-core watchdog flag
SNAP_REQ  in  1  single-cycle pulse that captures all DEBUG words
SNAP_ACK  out  1  one-cycle pulse, one cycle after the capture
SNAP_SEL  in  $clog2(NCORES) (min 1)  channel select for readout
SNAP_DATA  out  DW  registered shadow[SNAP_SEL]

Behaviour:
- Reset (XRES=0, asynchronous): CORE_RES='1; READY=0; STALL=0; SNAP_ACK=0; SNAP_DATA=0; shadows=0; FSM=HOLD; counters=0.
- FSM HOLD: count HOLD_CYCLES rising edges after XRES rises, then go to STAGGER. CORE_RES stays all-ones.
- FSM STAGGER: core k's CORE_RES clears on cycle k*STAGGER after HOLD exits (core 0 on the first STAGGER cycle). After core NCORES-1 releases, go to RUN. With STAGGER=0, all cores release on the same edge.
- FSM RUN: READY=1 (registered, same edge as the last release). RUN is terminal until XRES.
- Release latency: with STAGGER=0, CORE_RES goes low HOLD_CYCLES+1 edges after XRES deasserts.
- Watchdog, per core, active only while that core's CORE_RES=0:
  - Keep prev[k] and cnt[k].
  - DEBUG[k]!=prev[k] -> cnt=0.
  - Otherwise cnt increments and saturates at WDT_CYCLES.
  - cnt reaching WDT_CYCLES sets STALL[k]; STALL[k] clears only on XRES.
  - Counter width is $clog2(WDT_CYCLES+1).
- Snapshot:
  - SNAP_REQ=1 on an edge copies all NCORES DEBUG words into the shadows on that edge.
  - SNAP_ACK=1 on the next cycle, for exactly one cycle.
  - SNAP_REQ held high recaptures every cycle; SNAP_ACK then stays high, one cycle delayed.
  - SNAP_REQ is accepted in any FSM state.
- SNAP_DATA = shadow[SNAP_SEL], registered, 1-cycle latency from a SNAP_SEL change. SNAP_SEL>=NCORES returns 0.
- Simultaneous SNAP_REQ and SNAP_SEL change: SNAP_DATA reflects the new shadow contents one cycle after the capture edge.
- XRES asserted mid-sequence or mid-RUN: immediate return to reset values; the sequence restarts from HOLD.

Optional Feature:
DP_WDT_AUTORST_EN
- Defined: a STALL[k] rising edge re-asserts CORE_RES[k] for HOLD_CYCLES cycles, then releases it. cnt[k] restarts. STALL[k] stays sticky. READY is unaffected.
- Undefined: STALL is report-only; CORE_RES never re-asserts after RUN.

Decomposition:
- Package dp_ctrl_pkg holds:
  - FSM enum typedef (HOLD, STAGGER, RUN)
  - debug word typedef (logic [DW-1:0])
  - helper constant SELW = max(1, $clog2(NCORES))
- One natural sub-module, dp_wdt_chan: single-channel prev/counter/STALL logic, instantiated NCORES times via generate.

Test Plan:
- NCORES=4, HOLD=2, STAGGER=0: XRES rises at t0 -> CORE_RES 4'hF for 2 edges, 4'h0 on edge 3; READY=1 on the same edge.
- STAGGER=3: CORE_RES steps F->E->C->8->0 at 3-cycle spacing; READY rises with the 8->0 step.
- WDT_CYCLES=8, DEBUG[2] frozen at 32'hDEAD_BEEF and others toggling -> STALL=4'b0100 after 8 cycles; a toggle afterwards does not clear it.
- DEBUG={32'h3,32'h2,32'h1,32'h0}, pulse SNAP_REQ, then change DEBUG -> SNAP_ACK one cycle later; SNAP_SEL=2 gives SNAP_DATA=32'h2; SNAP_SEL=5 gives 0.
- XRES dropped during STAGGER after core 0 release -> CORE_RES=4'hF asynchronously, STALL=0; the full sequence repeats after XRES rises.
- DP_WDT_AUTORST_EN defined, WDT=8, HOLD=2: core 1 freezes -> CORE_RES[1] high for 2 cycles, then low; STALL[1] stays 1; READY stays 1.
